// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type and default bus widths for the memory arbiter
package mem_arbiter_pkg;
  localparam int MA_ADDR_BITS = 8;
  localparam int MA_DATA_BITS = 16;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELEASE    = 2'd3
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after the pointer
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  // scan from farthest to nearest offset so the nearest requester wins
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = j;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin four-phase arbiter sharing one memory among several consumers
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = MA_ADDR_BITS,
  parameter int DATA_BITS     = MA_DATA_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready
);
  localparam int N  = NUM_CONSUMERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, win_q, win_d;
  logic                   op_wr_q, op_wr_d;
  logic                   mrv_q, mrv_d, mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [N-1:0]           crr_q, crr_d, cwr_q, cwr_d;
  logic [N*DATA_BITS-1:0] crd_q, crd_d;
  logic [N-1:0]           elig;
  logic                   pick_v, grant, take_rd, rel;
  logic [IW-1:0]          pick_idx;

  assign elig    = (consumer_read_valid | consumer_write_valid) & ~crr_q & ~cwr_q;
  assign grant   = (state_q == IDLE) && pick_v && !mem_read_ready && !mem_write_ready;
  assign take_rd = consumer_read_valid[pick_idx];
  assign rel     = op_wr_q ? (!consumer_write_valid[win_q] && !mem_write_ready)
                           : (!consumer_read_valid[win_q] && !mem_read_ready);

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req_i  (elig),
    .ptr_i  (ptr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  // state and every registered output; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_wr_q <= 1'b0;
      mrv_q   <= 1'b0;
      mwv_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crr_q   <= '0;
      cwr_q   <= '0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_wr_q <= op_wr_d;
      mrv_q   <= mrv_d;
      mwv_q   <= mwv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crr_q   <= crr_d;
      cwr_q   <= cwr_d;
      crd_q   <= crd_d;
    end
  end

  // next state: one transaction at a time, held in RELEASE until both sides drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = grant ? (take_rd ? READ_WAIT : WRITE_WAIT) : IDLE;
      READ_WAIT:  state_d = mem_read_ready ? RELEASE : READ_WAIT;
      WRITE_WAIT: state_d = mem_write_ready ? RELEASE : WRITE_WAIT;
      RELEASE:    state_d = rel ? IDLE : RELEASE;
      default:    state_d = IDLE;
    endcase
  end

  // next values of the registered outputs and transaction context
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_wr_d = op_wr_q;
    mrv_d   = mrv_q;
    mwv_d   = mwv_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crr_d   = crr_q;
    cwr_d   = cwr_q;
    crd_d   = crd_q;
    if (grant) begin
      win_d   = pick_idx;
      op_wr_d = !take_rd;
      addr_d  = take_rd ? consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS]
                        : consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
      wdata_d = consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
      mrv_d   = take_rd;
      mwv_d   = !take_rd;
    end
    if (state_q == READ_WAIT && mem_read_ready) begin
      crd_d[win_q*DATA_BITS +: DATA_BITS] = mem_read_data;
      crr_d[win_q] = 1'b1;
      mrv_d        = 1'b0;
    end
    if (state_q == WRITE_WAIT && mem_write_ready) begin
      cwr_d[win_q] = 1'b1;
      mwv_d        = 1'b0;
    end
    if (state_q == RELEASE && rel) begin
      crr_d = '0;
      cwr_d = '0;
      ptr_d = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
    end
  end

  assign consumer_read_ready  = crr_q;
  assign consumer_write_ready = cwr_q;
  assign consumer_read_data   = crd_q;
  assign mem_read_valid       = mrv_q;
  assign mem_write_valid      = mwv_q;
  assign mem_read_address     = addr_q;
  assign mem_write_address    = addr_q;
  assign mem_write_data       = wdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting ports.
REQ-002 SHALL have parameter ADDR_BITS, default 8, address width.
REQ-003 SHALL have parameter DATA_BITS, default 16, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-007 SHALL have port consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at slice i.
REQ-008 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-consumer read done.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data.
REQ-010 SHALL have port consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-011 SHALL have port consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
REQ-012 SHALL have port consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data.
REQ-013 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-consumer write done.
REQ-014 SHALL have ports mem_read_valid/mem_read_address (out 1/ADDR_BITS), mem_read_ready/mem_read_data (in 1/DATA_BITS) to the memory read channel.
REQ-015 SHALL have ports mem_write_valid/mem_write_address/mem_write_data (out 1/ADDR_BITS/DATA_BITS), mem_write_ready (in 1) to the memory write channel.

Function
REQ-016 Handshake on both sides SHALL be four-phase: requester holds valid until ready; responder holds ready until valid drops.
REQ-017 SHALL serve one transaction at a time via FSM states IDLE, READ_WAIT, WRITE_WAIT, RELEASE; all outputs registered.
REQ-018 IDLE: a consumer is eligible if its read_valid or write_valid is high and its read_ready/write_ready is low; winner = first eligible index at or after rr_pointer, modulo NUM_CONSUMERS.
REQ-019 Within the winning consumer, read SHALL take precedence over write when both are pending.
REQ-020 On grant (cycle t), the winner's address (and write data) SHALL be latched and mem_*_valid asserted at t+1; state -> READ_WAIT or WRITE_WAIT.
REQ-021 READ_WAIT: on mem_read_ready high, capture mem_read_data into the winner's consumer_read_data slice, set consumer_read_ready[winner], clear mem_read_valid, state -> RELEASE.
REQ-022 WRITE_WAIT: on mem_write_ready high, set consumer_write_ready[winner], clear mem_write_valid, state -> RELEASE.
REQ-023 RELEASE: when the winner's matching valid is low AND the matching mem_*_ready is low, clear consumer ready, rr_pointer <= winner+1 (wrap to 0 after NUM_CONSUMERS-1), state -> IDLE.
REQ-024 No new memory request SHALL issue while mem_read_ready or mem_write_ready is still high.
REQ-025 consumer_read_data slices SHALL hold last captured value until overwritten by a later read for that consumer.
REQ-026 Requests arriving or changing mid-transaction SHALL not affect the current transaction; they are arbitrated at the next IDLE.
REQ-027 No eligible consumers in IDLE: remain IDLE, all valids low, pointer unchanged.

Reset
REQ-028 reset low SHALL immediately clear every output to 0, rr_pointer to 0, state to IDLE, regardless of clock.
REQ-029 Reset mid-transaction SHALL abandon it with no retry; release on the first rising edge after reset goes high.

Structure
REQ-030 Shared package SHALL hold FSM state typedef (2-bit) and default ADDR_BITS/DATA_BITS constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_picker (request vector + pointer -> valid + index), combinational.

Verification
REQ-032 Consumer 2 writes 0xBEEF to 0x12, then consumer 0 reads 0x12 -> consumer_read_data slice 0 = 0xBEEF, ready pulses once each.
REQ-033 After reset all four consumers assert read_valid together -> mem_read_valid grants in order 0,1,2,3, one at a time.
REQ-034 Consumer 1 served first, then all four request -> order 2,3,0,1 (pointer wrap).
REQ-035 Consumer 3 asserts read and write simultaneously -> read served first, then write on a later grant.
REQ-036 Reset low while in READ_WAIT -> all outputs 0 asynchronously; after release, fresh request from consumer 0 completes correctly.
REQ-037 Consumer holds valid 5 cycles after ready -> consumer ready stays high, no other grant until valid drops.
